// File: rtl/issue_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : issue_sched_pkg
// Description : Shared types and constants for the N-wide in-order issue
//               scheduler and its multi-port scoreboard. Provides the
//               issue-queue entry and FU packet types, the FU class enum,
//               register/queue address types and the default per-class
//               structural limits.
// Revision    : 1.0 - initial release
// ============================================================================
package issue_sched_pkg;

    localparam int c_REG_ADDR_W  = 5;
    localparam int c_REG_SPACE   = 1 << c_REG_ADDR_W;
    localparam int c_IQ_ADDR_W   = 4;
    localparam int c_PAYLOAD_W   = 32;

    localparam int c_DEF_MAX_ALU = 2;
    localparam int c_DEF_MAX_LSU = 1;
    localparam int c_DEF_MAX_BR  = 1;

    typedef logic [c_REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [c_IQ_ADDR_W-1:0]  iq_addr_t;

    typedef enum logic [2:0] {
        FU_ALU        = 3'd0,
        FU_MULDIV_MUL = 3'd1,
        FU_MULDIV_DIV = 3'd2,
        FU_LSU        = 3'd3,
        FU_BR         = 3'd4
    } fu_type_e;

    typedef struct packed {
        reg_addr_t              rs;
        reg_addr_t              rt;
        reg_addr_t              rd;
        logic                   rs_used;
        logic                   rt_used;
        logic                   rd_used;
        fu_type_e               fu_type;
        logic [c_PAYLOAD_W-1:0] payload;
    } issue_queue_element_t;

    typedef struct packed {
        logic                 valid;
        issue_queue_element_t inst;
    } fu_require_t;

    function automatic logic is_muldiv(input fu_type_e t);
        return (t == FU_MULDIV_MUL) || (t == FU_MULDIV_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/issue_sched_score_board_mp.sv
`default_nettype none
// ============================================================================
// Module      : score_board_mp
// Description : Multi-port pending-write scoreboard. One pending bit per
//               architectural register (r0 never pending). ISSUE_WIDTH set
//               ports, WB_PORTS clear ports, synchronous flush clear.
//               Set wins over clear on the same register in the same cycle.
//               Optional macro ISSUE_WB_BYPASS_EN: registers being cleared
//               this cycle read as not pending (same-cycle wakeup).
// Ports       : clk, rst (async, active-high), flush,
//               set_en/set_addr  - issued destinations,
//               wb_valid/wb_addr - writeback clears,
//               pending          - hazard view, padded to full address space.
// Revision    : 1.0 - initial release
// ============================================================================
module score_board_mp
    import issue_sched_pkg::*;
#(
    parameter int NUM_REGS    = 32,
    parameter int ISSUE_WIDTH = 2,
    parameter int WB_PORTS    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [ISSUE_WIDTH-1:0] set_en,
    input  reg_addr_t              set_addr [ISSUE_WIDTH],
    input  logic [WB_PORTS-1:0]    wb_valid,
    input  reg_addr_t              wb_addr  [WB_PORTS],
    output logic [c_REG_SPACE-1:0] pending
);

    logic [NUM_REGS-1:0] r_pending;
    logic [NUM_REGS-1:0] w_clr;
    logic [NUM_REGS-1:0] w_set;
    logic [NUM_REGS-1:0] w_view;

    // Decode port addresses into per-register masks; r0 is skipped so it
    // can never become pending.
    always_comb begin
        w_clr = '0;
        w_set = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            for (int p = 0; p < WB_PORTS; p++) begin
                if (wb_valid[p] && (wb_addr[p] == reg_addr_t'(r))) w_clr[r] = 1'b1;
            end
            for (int s = 0; s < ISSUE_WIDTH; s++) begin
                if (set_en[s] && (set_addr[s] == reg_addr_t'(r))) w_set[r] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
        end else if (flush) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_set;
        end
    end

`ifdef ISSUE_WB_BYPASS_EN
    assign w_view = r_pending & ~w_clr;
`else
    assign w_view = r_pending;
`endif

    // Pad to the full address space so callers can index with any reg_addr_t.
    generate
        for (genvar r = 0; r < c_REG_SPACE; r++) begin : g_view
            if (r < NUM_REGS) begin : g_real
                assign pending[r] = w_view[r];
            end else begin : g_pad
                assign pending[r] = 1'b0;
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/issue_sched.sv
`default_nettype none
// ============================================================================
// Module      : issue_sched
// Description : Parametrised in-order N-wide issue scheduler. Examines the
//               oldest ISSUE_WIDTH queue entries and issues the longest
//               hazard-free in-order prefix (RAW/WAW via scoreboard,
//               intra-group RAW, per-class FU limits, MUL/DIV busy).
//               Optional macro ISSUE_WB_BYPASS_EN enables same-cycle
//               writeback wakeup in the scoreboard.
// Ports       : clk, rst (async, active-high),
//               issue_require[ISSUE_WIDTH] - queue head, index 0 oldest,
//               iq_size       - valid entries in queue,
//               flush         - pipeline flush,
//               wb_valid/wb_addr - writeback ports,
//               iq_pop_number - entries issued this cycle (combinational),
//               fu_require    - registered issue packets.
// Revision    : 1.0 - initial release
// ============================================================================
module issue_sched
    import issue_sched_pkg::*;
#(
    parameter int ISSUE_WIDTH = 2,
    parameter int WB_PORTS    = 2,
    parameter int NUM_REGS    = 32,
    parameter int DIV_LAT     = 8,
    parameter int MAX_ALU     = c_DEF_MAX_ALU,
    parameter int MAX_LSU     = c_DEF_MAX_LSU,
    parameter int MAX_BR      = c_DEF_MAX_BR
) (
    input  logic                               clk,
    input  logic                               rst,
    input  issue_queue_element_t               issue_require [ISSUE_WIDTH],
    input  iq_addr_t                           iq_size,
    input  logic                               flush,
    input  logic [WB_PORTS-1:0]                wb_valid,
    input  reg_addr_t                          wb_addr [WB_PORTS],
    output logic [$clog2(ISSUE_WIDTH+1)-1:0]   iq_pop_number,
    output fu_require_t                        fu_require [ISSUE_WIDTH]
);

    localparam int c_POP_W  = $clog2(ISSUE_WIDTH + 1);
    localparam int c_BUSY_W = $clog2(DIV_LAT);

    logic [c_REG_SPACE-1:0] w_pending;
    logic [ISSUE_WIDTH-1:0] w_issue;
    logic [ISSUE_WIDTH-1:0] w_set_en;
    reg_addr_t              w_set_addr [ISSUE_WIDTH];
    logic                   w_div_issue;
    logic [c_BUSY_W-1:0]    r_div_busy;
    fu_require_t            r_fu_require [ISSUE_WIDTH];

    // Walk the head entries oldest first; the first blocked entry ends the
    // group so issue stays strictly in order.
    always_comb begin : p_select
        logic                   alive;
        logic                   ok;
        logic                   md_seen;
        logic [c_REG_SPACE-1:0] grp_dst;
        int                     alu_n;
        int                     lsu_n;
        int                     br_n;

        alive         = 1'b1;
        ok            = 1'b0;
        md_seen       = 1'b0;
        grp_dst       = '0;
        alu_n         = 0;
        lsu_n         = 0;
        br_n          = 0;
        w_issue       = '0;
        w_div_issue   = 1'b0;
        iq_pop_number = '0;

        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            ok = alive && !flush &&
                 ((int'(iq_size) >= ISSUE_WIDTH) || (int'(iq_size) > i));

            if (issue_require[i].rs_used &&
                (w_pending[issue_require[i].rs] || grp_dst[issue_require[i].rs])) ok = 1'b0;
            if (issue_require[i].rt_used &&
                (w_pending[issue_require[i].rt] || grp_dst[issue_require[i].rt])) ok = 1'b0;
            if (issue_require[i].rd_used && w_pending[issue_require[i].rd]) ok = 1'b0;

            case (issue_require[i].fu_type)
                FU_ALU:        if (alu_n >= MAX_ALU) ok = 1'b0;
                FU_LSU:        if (lsu_n >= MAX_LSU) ok = 1'b0;
                FU_BR:         if (br_n  >= MAX_BR)  ok = 1'b0;
                FU_MULDIV_MUL,
                FU_MULDIV_DIV: if ((r_div_busy != '0) || md_seen) ok = 1'b0;
                default:       ok = 1'b0;
            endcase

            if (ok) begin
                w_issue[i]    = 1'b1;
                iq_pop_number = c_POP_W'(i + 1);
                case (issue_require[i].fu_type)
                    FU_ALU:  alu_n++;
                    FU_LSU:  lsu_n++;
                    FU_BR:   br_n++;
                    default: ;
                endcase
                if (is_muldiv(issue_require[i].fu_type)) md_seen = 1'b1;
                if (issue_require[i].fu_type == FU_MULDIV_DIV) w_div_issue = 1'b1;
                // r0 never creates a dependency, even inside the group.
                if (issue_require[i].rd_used && (issue_require[i].rd != '0))
                    grp_dst[issue_require[i].rd] = 1'b1;
            end else begin
                alive = 1'b0;
            end
        end
    end

    generate
        for (genvar i = 0; i < ISSUE_WIDTH; i++) begin : g_set
            assign w_set_en[i]   = w_issue[i] && issue_require[i].rd_used;
            assign w_set_addr[i] = issue_require[i].rd;
        end
    endgenerate

    score_board_mp #(
        .NUM_REGS    (NUM_REGS),
        .ISSUE_WIDTH (ISSUE_WIDTH),
        .WB_PORTS    (WB_PORTS)
    ) u_score_board (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .set_en   (w_set_en),
        .set_addr (w_set_addr),
        .wb_valid (wb_valid),
        .wb_addr  (wb_addr),
        .pending  (w_pending)
    );

    // Issued set is always a prefix, so slot i carries entry i directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ISSUE_WIDTH; i++) begin
                r_fu_require[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ISSUE_WIDTH; i++) begin
                r_fu_require[i].valid <= w_issue[i];
                r_fu_require[i].inst  <= issue_require[i];
            end
        end
    end

    assign fu_require = r_fu_require;

    // DIV keeps the MUL/DIV unit for DIV_LAT cycles including its issue cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_busy <= '0;
        end else if (flush) begin
            r_div_busy <= '0;
        end else if (w_div_issue) begin
            r_div_busy <= c_BUSY_W'(DIV_LAT - 1);
        end else if (r_div_busy != '0) begin
            r_div_busy <= r_div_busy - 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_issue_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_issue_sched
// Description : Directed self-checking bench for issue_sched (ISSUE_WIDTH=3,
//               other parameters default). Expected values are hand-derived.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_issue_sched;
    import issue_sched_pkg::*;

    localparam int W = 3;
`ifdef ISSUE_WB_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 flush;
    issue_queue_element_t iq [W];
    iq_addr_t             iq_size;
    logic [1:0]           wb_valid;
    reg_addr_t            wb_addr [2];
    logic [1:0]           pop;
    fu_require_t          fu [W];

    int n_checks = 0;
    int n_errors = 0;

    issue_sched #(.ISSUE_WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .issue_require (iq),
        .iq_size       (iq_size),
        .flush         (flush),
        .wb_valid      (wb_valid),
        .wb_addr       (wb_addr),
        .iq_pop_number (pop),
        .fu_require    (fu)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Register arguments < 0 mean "field unused".
    function automatic issue_queue_element_t mk(input fu_type_e t, input int rs,
                                                input int rt, input int rd,
                                                input int pl);
        issue_queue_element_t e;
        e         = '0;
        e.fu_type = t;
        e.rs_used = (rs >= 0);
        e.rt_used = (rt >= 0);
        e.rd_used = (rd >= 0);
        e.rs      = (rs >= 0) ? reg_addr_t'(rs) : '0;
        e.rt      = (rt >= 0) ? reg_addr_t'(rt) : '0;
        e.rd      = (rd >= 0) ? reg_addr_t'(rd) : '0;
        e.payload = 32'(pl);
        return e;
    endfunction

    task automatic clear_q();
        for (int i = 0; i < W; i++) iq[i] = '0;
        iq_size = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_q();
        flush    = 1'b0;
        wb_valid = '0;
        wb_addr  = '{default: '0};
        rst      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pop", int'(pop), 0);
        check("rst_v0", int'(fu[0].valid), 0);
        check("rst_v2", int'(fu[2].valid), 0);
        rst = 1'b0;

        // Two independent ALU ops
        iq[0] = mk(FU_ALU, 10, -1, 1, 100);
        iq[1] = mk(FU_ALU, 11, -1, 2, 101);
        iq_size = 2;
        #1 check("pair_pop", int'(pop), 2);
        tick();
        check("pair_v0", int'(fu[0].valid), 1);
        check("pair_v1", int'(fu[1].valid), 1);
        check("pair_v2", int'(fu[2].valid), 0);
        check("pair_pl1", int'(fu[1].inst.payload), 101);
        clear_q();
        iq[0] = mk(FU_ALU, 1, -1, -1, 102);
        iq_size = 1;
        #1 check("r1_pending", int'(pop), 0);
        wb_valid = 2'b11; wb_addr[0] = 5'd1; wb_addr[1] = 5'd2;
        #1 check("r1_wb_same", int'(pop), BYP);
        tick();
        wb_valid = '0;
        #1 check("r1_wb_next", int'(pop), 1);
        tick();
        clear_q();

        // Intra-group RAW on r5
        iq[0] = mk(FU_ALU, -1, -1, 5, 200);
        iq[1] = mk(FU_ALU, 5, -1, 6, 201);
        iq_size = 2;
        #1 check("grp_raw_pop", int'(pop), 1);
        tick();
        check("grp_v0", int'(fu[0].valid), 1);
        check("grp_v1", int'(fu[1].valid), 0);
        check("grp_pl0", int'(fu[0].inst.payload), 200);
        iq[0] = mk(FU_ALU, 5, -1, 6, 201);
        iq[1] = '0;
        iq_size = 1;
        #1 check("raw_wait", int'(pop), 0);
        wb_valid = 2'b01; wb_addr[0] = 5'd5;
        #1 check("raw_wb_same", int'(pop), BYP);
        tick();
        wb_valid = '0;
        // With bypass the consumer already issued, so r6 is now a WAW hazard.
        #1 check("raw_wb_next", int'(pop), 1 - BYP);
        tick();
        clear_q();
        wb_valid = 2'b01; wb_addr[0] = 5'd6;
        tick();
        wb_valid = '0;

        // DIV busy window
        iq[0] = mk(FU_MULDIV_DIV, -1, -1, -1, 300);
        iq[1] = mk(FU_MULDIV_MUL, -1, -1, -1, 301);
        iq[2] = mk(FU_ALU, -1, -1, -1, 302);
        iq_size = 3;
        #1 check("div_grp", int'(pop), 1);
        tick();
        for (int k = 1; k <= 7; k++) begin
            if (k == 4) begin
                iq[0] = mk(FU_ALU, -1, -1, -1, 310);
                iq[1] = mk(FU_MULDIV_MUL, -1, -1, -1, 311);
                iq_size = 2;
                #1 check("div_alu_pass", int'(pop), 1);
            end else begin
                iq[0] = mk(FU_MULDIV_MUL, -1, -1, -1, 320 + k);
                iq_size = 1;
                #1 check($sformatf("div_blk%0d", k), int'(pop), 0);
            end
            tick();
        end
        iq[0] = mk(FU_MULDIV_MUL, -1, -1, -1, 330);
        iq[1] = '0;
        iq_size = 1;
        #1 check("mul_c8", int'(pop), 1);
        tick();
        check("mul_v0", int'(fu[0].valid), 1);
        check("mul_pl0", int'(fu[0].inst.payload), 330);
        iq[0] = mk(FU_MULDIV_MUL, -1, -1, -1, 331);
        #1 check("mul_back", int'(pop), 1);
        tick();
        clear_q();

        // Set wins over same-cycle clear on r7
        wb_valid = 2'b01; wb_addr[0] = 5'd7;
        iq[0] = mk(FU_ALU, -1, -1, 7, 400);
        iq_size = 1;
        #1 check("setwin_pop", int'(pop), 1);
        tick();
        wb_valid = '0;
        iq[0] = mk(FU_ALU, 7, -1, -1, 401);
        #1 check("setwin_r7", int'(pop), 0);
        iq_size = 0;
        wb_valid = 2'b01; wb_addr[0] = 5'd7;
        tick();
        wb_valid = '0;

        // Structural limits
        for (int i = 0; i < W; i++) iq[i] = mk(FU_LSU, -1, -1, -1, 500 + i);
        iq_size = 3;
        #1 check("lsu_3", int'(pop), 1);
        tick();
        check("lsu_v1", int'(fu[1].valid), 0);
        iq_size = 2;
        #1 check("lsu_2", int'(pop), 1);
        tick();
        iq_size = 1;
        #1 check("lsu_1", int'(pop), 1);
        tick();
        for (int i = 0; i < W; i++) iq[i] = mk(FU_ALU, -1, -1, -1, 510 + i);
        iq_size = 3;
        #1 check("alu_lim", int'(pop), 2);
        iq[0] = mk(FU_BR, -1, -1, -1, 520);
        iq[1] = mk(FU_BR, -1, -1, -1, 521);
        iq_size = 2;
        #1 check("br_lim", int'(pop), 1);
        iq_size = 0;
        #1 check("empty_q", int'(pop), 0);
        iq[0] = mk(FU_ALU, -1, -1, -1, 530);
        iq[1] = mk(FU_LSU, -1, -1, -1, 531);
        iq[2] = mk(FU_BR,  -1, -1, -1, 532);
        iq_size = 9;
        #1 check("big_size", int'(pop), 3);
        tick();
        check("big_v2", int'(fu[2].valid), 1);
        check("big_pl2", int'(fu[2].inst.payload), 532);
        clear_q();

        // Flush with r3 pending and div_busy = 4
        iq[0] = mk(FU_ALU, -1, -1, 3, 600);
        iq[1] = mk(FU_MULDIV_DIV, -1, -1, -1, 601);
        iq_size = 2;
        #1 check("fl_setup", int'(pop), 2);
        tick();
        clear_q();
        repeat (3) tick();
        flush = 1'b1;
        iq[0] = mk(FU_ALU, -1, -1, -1, 602);
        iq_size = 1;
        #1 check("fl_pop", int'(pop), 0);
        tick();
        flush = 1'b0;
        check("fl_v0", int'(fu[0].valid), 0);
        check("fl_v1", int'(fu[1].valid), 0);
        iq[0] = mk(FU_ALU, 3, -1, -1, 603);
        iq[1] = mk(FU_MULDIV_MUL, -1, -1, -1, 604);
        iq_size = 2;
        #1 check("fl_after", int'(pop), 2);
        tick();
        clear_q();

        // Asynchronous reset mid-operation
        iq[0] = mk(FU_ALU, -1, -1, 4, 700);
        iq_size = 1;
        tick();
        check("ar_v0", int'(fu[0].valid), 1);
        clear_q();
        #2 rst = 1'b1;
        #1 check("ar_v0_rst", int'(fu[0].valid), 0);
        rst = 1'b0;
        iq[0] = mk(FU_ALU, 4, -1, -1, 701);
        iq_size = 1;
        #1 check("ar_pop", int'(pop), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
